mult_div_seq: RTL and testbench



---
 rtl/mult_div_seq.sv | 192 +++++++++++++++++++
 tb/tb_mult_div_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_seq.sv
// Multicycle multiply/divide sequencer owning HI/LO: radix-2 Booth multiply, restoring divide with sign fix.
// Optional macro UNSIGNED_OPS_EN adds op_unsigned for multu/divu.
module mult_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef UNSIGNED_OPS_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [WIDTH:0]   m_q, m_d;
  logic             is_div_q, is_div_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             hi_fix_q, hi_fix_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             uns;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   shifted;
  logic             ge;

`ifdef UNSIGNED_OPS_EN
  assign uns = op_unsigned;
`else
  assign uns = 1'b0;
`endif

  assign a_neg = op_a[WIDTH-1] & ~uns;
  assign b_neg = op_b[WIDTH-1] & ~uns;
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    is_div_d  = is_div_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    hi_fix_d  = hi_fix_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    booth_sum = acc_q;
    shifted   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    ge        = (shifted >= m_q);

    unique case ({q_q[0], q1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start_mult) begin
          acc_d    = '0;
          q_d      = op_b;
          q1_d     = 1'b0;
          m_d      = {op_a[WIDTH-1] & ~uns, op_a};
          // Booth treats the multiplier as signed; an unsigned one needs m added into hi
          hi_fix_d = uns & op_b[WIDTH-1];
          is_div_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = MULT;
        end else if (start_div) begin
          if (op_b != '0) begin
            acc_d    = '0;
            q_d      = a_mag;
            m_d      = {1'b0, b_mag};
            neg_q_d  = a_neg ^ b_neg;
            neg_r_d  = a_neg;
            is_div_d = 1'b1;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = DIV;
          end else begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end
        end
      end
      MULT: begin
        acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
      end
      DIV: begin
        acc_d = ge ? (shifted - m_q) : shifted;
        q_d   = {q_q[WIDTH-2:0], ge};
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = neg_q_q ? -q_q : q_q;
          hi_d = neg_r_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end else begin
          lo_d = q_q;
          hi_d = acc_q[WIDTH-1:0] + (hi_fix_q ? m_q[WIDTH-1:0] : '0);
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == MULT || state_q == DIV) begin
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d   = '0;
        state_d = FIX;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_fix_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      hi_fix_q <= hi_fix_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: expected HI/LO pushed at start, popped on done.
module tb_mult_div_seq;
  localparam int unsigned WIDTH = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              start_mult, start_div;
  logic [WIDTH-1:0]  op_a, op_b;
  logic              busy, done, div_zero;
  logic [WIDTH-1:0]  hi, lo;
`ifdef UNSIGNED_OPS_EN
  logic              op_unsigned = 1'b0;
`endif

  mult_div_seq #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
`ifdef UNSIGNED_OPS_EN
    .op_unsigned(op_unsigned),
`endif
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, p, qt, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    if (!is_div) begin
      p    = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = exp_hi;
      e.lo = exp_lo;
      e.dz = 1'b1;
    end else begin
      qt   = sa / sb;
      rm   = sa % sb;
      e.hi = rm[31:0];
      e.lo = qt[31:0];
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("div_zero", div_zero, mon_e.dz);
      end
    end
  end

  // Caller sits #1 after a rising edge; the next edge is E0.
  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, input int poke);
    exp_t e;
    bit   zdiv;
    int   n;
    zdiv = !m && d && (b == 32'd0);
    start_mult = m;
    start_div  = d;
    op_a = a;
    op_b = b;
    e = model(!m, a, b);
    sb_q.push_back(e);
    exp_hi = e.hi;
    exp_lo = e.lo;
    @(posedge clock); #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    check("busy_after_e0", busy, zdiv ? 64'd0 : 64'd1);
    n = 0;
    while (!done && n < 40) begin
      if (n + 1 == poke) begin
        start_div = 1'b1;
        op_b = '0;
      end
      if (n == poke) start_div = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    start_div = 1'b0;
    check("latency", n, zdiv ? 64'd0 : 64'(WIDTH + 1));
    check("busy_at_done", busy, 64'd0);
    if (!b2b) begin
      @(posedge clock); #1;
      check("done_pulse", done, 64'd0);
      check("dz_pulse", div_zero, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start_mult = 1'b0;
    start_div = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_busy", busy, 64'd0);
    check("rst_done", done, 64'd0);
    check("rst_dz", div_zero, 64'd0);
    check("rst_hi", hi, 64'd0);
    check("rst_lo", lo, 64'd0);

    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(1, 0, 32'd5, 32'd6, 0, 0);
    run_op(0, 1, 32'd99, 32'd0, 0, 0);
    run_op(1, 1, 32'd1234, 32'hFFFF_FF00, 0, 10);
    repeat (3) @(posedge clock);
    #1;
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, 0);

    // Abort a multiply at edge 15 with reset; nothing is pushed for it.
    start_mult = 1'b1;
    op_a = 32'h8000_0000;
    op_b = 32'h8000_0000;
    @(posedge clock); #1;
    start_mult = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_busy", busy, 64'd0);
    check("abort_done", done, 64'd0);
    check("abort_dz", div_zero, 64'd0);
    check("abort_hi", hi, 64'd0);
    check("abort_lo", lo, 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    repeat (2) @(posedge clock);
    #1;
    run_op(1, 0, 32'd3, 32'd4, 0, 0);

    // Back-to-back: each new start lands on the edge right after done.
    run_op(0, 1, 32'd100, 32'hFFFF_FFF9, 1, 0);
    run_op(0, 1, 32'd5, 32'd0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      run_op(i[0], !i[0], $urandom, $urandom_range(200, 1) * (i[1] ? 32'hFFFF_FFFF : 32'd1), 1, 0);
    end
    run_op(1, 0, $urandom, $urandom, 0, 0);

    repeat (5) @(posedge clock);
    #1;
    check("sb_empty", sb_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
